// File: rtl/tff_counter_bank.sv
// WIDTH-bit register bank: per-bit T flip-flops or a modulo-(MAX_COUNT+1)
// up/down/Gray counter with synchronous load and a registered terminal-count pulse.
module tff_counter_bank #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = (1 << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] t_in,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  localparam logic [1:0]       MODE_TOGGLE = 2'b00;
  localparam logic [1:0]       MODE_UP     = 2'b01;
  localparam logic [1:0]       MODE_DOWN   = 2'b10;
  localparam logic [1:0]       MODE_GRAY   = 2'b11;
  localparam logic [WIDTH-1:0] MAX_C       = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ZERO_C      = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C       = WIDTH'(1);

  logic [WIDTH-1:0] cnt_r;
  logic             tc_r;
  logic [WIDTH-1:0] cnt_nxt_s;
  logic             tc_nxt_s;

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] clamp_max(input logic [WIDTH-1:0] v);
    return (v > MAX_C) ? MAX_C : v;
  endfunction

  // Next-state selection: load beats enable, idle cycles hold and drop tc.
  always_comb begin
    cnt_nxt_s = cnt_r;
    tc_nxt_s  = 1'b0;
    if (load) begin
      if (mode == MODE_TOGGLE) begin
        cnt_nxt_s = load_value;
      end else begin
        cnt_nxt_s = clamp_max(load_value);
      end
    end else if (enable) begin
      case (mode)
        MODE_TOGGLE: begin
          cnt_nxt_s = cnt_r ^ t_in;
        end
        MODE_UP, MODE_GRAY: begin
          // Out-of-range values left by toggle mode recover to 0 without a pulse.
          if (cnt_r >= MAX_C) begin
            cnt_nxt_s = ZERO_C;
            tc_nxt_s  = (cnt_r == MAX_C);
          end else begin
            cnt_nxt_s = cnt_r + ONE_C;
          end
        end
        MODE_DOWN: begin
          if (cnt_r == ZERO_C) begin
            cnt_nxt_s = MAX_C;
            tc_nxt_s  = 1'b1;
          end else if (cnt_r > MAX_C) begin
            cnt_nxt_s = MAX_C;
          end else begin
            cnt_nxt_s = cnt_r - ONE_C;
          end
        end
        default: begin
          cnt_nxt_s = cnt_r;
        end
      endcase
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= ZERO_C;
      tc_r  <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      tc_r  <= tc_nxt_s;
    end
  end

  // Output encoding follows the current mode so 01->11 switches without a cycle penalty.
  always_comb begin
    q = cnt_r;
    case (mode)
      MODE_GRAY: q = bin2gray(cnt_r);
      default:   q = cnt_r;
    endcase
  end

  assign tc = tc_r;

endmodule

// File: tb/tb_tff_counter_bank.sv
// Scoreboard bench: two banks (MAX_COUNT 9 and 15) share stimulus; a reference
// model queues expected q/tc per edge and a negedge monitor compares.
module tb_tff_counter_bank;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         load = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] t_in = '0;
  logic [W-1:0] q_a, q_b;
  logic         tc_a, tc_b;

  typedef struct {
    int qa;
    bit tca;
    int qb;
    bit tcb;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   mcnt[2] = '{0, 0};
  int   mmax[2] = '{9, 15};

  always #5 clk = ~clk;

  tff_counter_bank #(.WIDTH(W), .MAX_COUNT(9)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .load(load),
    .load_value(load_value), .t_in(t_in), .q(q_a), .tc(tc_a)
  );

  tff_counter_bank #(.WIDTH(W), .MAX_COUNT(15)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .load(load),
    .load_value(load_value), .t_in(t_in), .q(q_b), .tc(tc_b)
  );

  // Reference behaviour on plain integers for bank u; returns visible q and tc.
  function automatic void advance(input int u, output int q_exp, output bit tc_exp);
    int c, mx, lv, t;
    c = mcnt[u];
    mx = mmax[u];
    lv = int'(load_value);
    t = int'(t_in);
    tc_exp = 1'b0;
    if (reset) begin
      c = 0;
    end else if (load) begin
      c = (mode == 2'd0) ? lv : ((lv < mx) ? lv : mx);
    end else if (enable) begin
      if (mode == 2'd0) begin
        c = c ^ t;
      end else if (mode == 2'd2) begin
        if (c == 0) begin
          c = mx;
          tc_exp = 1'b1;
        end else if (c > mx) begin
          c = mx;
        end else begin
          c = c - 1;
        end
      end else begin
        if (c >= mx) begin
          tc_exp = (c == mx);
          c = 0;
        end else begin
          c = c + 1;
        end
      end
    end
    mcnt[u] = c;
    q_exp = (mode == 2'd3) ? (c ^ (c >> 1)) : c;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit ld, input bit en, input logic [1:0] md,
                      input int lv, input int t);
    exp_t e;
    reset = r;
    load = ld;
    enable = en;
    mode = md;
    load_value = lv[W-1:0];
    t_in = t[W-1:0];
    @(posedge clk);
    advance(0, e.qa, e.tca);
    advance(1, e.qb, e.tcb);
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  // Monitor: every output cycle that has a queued expectation is compared.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("q_max9", int'(q_a), e.qa);
      chk("tc_max9", int'(tc_a), int'(e.tca));
      chk("q_max15", int'(q_b), e.qb);
      chk("tc_max15", int'(tc_b), int'(e.tcb));
    end
  end

  initial begin
    // Count up with wrap at 9.
    step(1, 0, 0, 2'd1, 0, 0);
    repeat (12) step(0, 0, 1, 2'd1, 0, 0);
    // Count down from 0, then hold.
    step(1, 0, 0, 2'd2, 0, 0);
    repeat (3) step(0, 0, 1, 2'd2, 0, 0);
    repeat (3) step(0, 0, 0, 2'd2, 0, 0);
    // Toggle bank.
    step(1, 0, 0, 2'd0, 0, 0);
    repeat (3) step(0, 0, 1, 2'd0, 0, 5);
    repeat (2) step(0, 0, 1, 2'd0, 0, 0);
    repeat (2) step(0, 0, 0, 2'd0, 0, 15);
    // Load clamping, out-of-range recovery, load beats enable.
    step(0, 1, 0, 2'd1, 14, 0);
    step(0, 1, 0, 2'd0, 14, 0);
    step(0, 0, 1, 2'd1, 0, 0);
    step(0, 1, 1, 2'd1, 3, 0);
    // Gray sequence through a full wrap.
    step(1, 0, 0, 2'd3, 0, 0);
    repeat (16) step(0, 0, 1, 2'd3, 0, 0);
    // Reset overrides load mid-count.
    step(1, 0, 0, 2'd1, 0, 0);
    repeat (6) step(0, 0, 1, 2'd1, 0, 0);
    step(1, 1, 1, 2'd1, 2, 0);
    step(0, 0, 1, 2'd1, 0, 0);
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 40) == 0, ($urandom % 8) == 0, ($urandom % 4) != 0,
           2'($urandom % 4), int'($urandom % 16), int'($urandom % 16));
    end
    repeat (2) @(negedge clk);
    #2;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tff_counter_bank.md
Name: tff_counter_bank

Overview:
Parametrised successor to the single T flip-flop: a WIDTH-bit register bank built on toggle semantics. It operates either as independent per-bit T flip-flops or as a modulo-(MAX_COUNT+1) up, down or Gray-code counter. It adds synchronous load, a registered terminal-count pulse and run-time mode switching, and sits wherever the design previously instantiated discrete T flip-flops or small counters.

Parameters:
WIDTH, 4, register width in bits (>=2)
MAX_COUNT, 2**WIDTH-1, highest count value in counting modes; wrap point (1 <= MAX_COUNT <= 2**WIDTH-1)

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  advance/toggle enable
mode  input  2  00 toggle bank, 01 count up, 10 count down, 11 Gray up
load  input  1  synchronous load strobe
load_value  input  WIDTH  value written on load
t_in  input  WIDTH  per-bit toggle inputs (mode 00 only)
q  output  WIDTH  bank output
tc  output  1  terminal-count pulse, registered

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset.
- State: internal register cnt[WIDTH-1:0] and register tc.
- q = cnt in modes 00/01/10; q = cnt ^ (cnt >> 1) in mode 11. q is a combinational function of cnt and mode only, with no input-to-output path other than mode.
- Priority per rising edge: reset > load > enable > hold.
- reset=1: cnt <= 0, tc <= 0. q=0 in every mode. Reset mid-count takes effect on the same edge and overrides load/enable.
- load=1, reset=0: independent of enable.
  - Mode 00: cnt <= load_value.
  - Other modes: cnt <= min(load_value, MAX_COUNT).
  - tc <= 0.
- enable=1, load=0, reset=0:
  - 00: cnt <= cnt ^ t_in. Each bit is a T flip-flop. tc <= 0.
  - 01 and 11: if cnt >= MAX_COUNT, cnt <= 0 and tc <= (cnt == MAX_COUNT). Otherwise cnt <= cnt+1 and tc <= 0.
  - 10: if cnt == 0, cnt <= MAX_COUNT and tc <= 1. If cnt > MAX_COUNT, cnt <= MAX_COUNT and tc <= 0. Otherwise cnt <= cnt-1 and tc <= 0.
- enable=0, load=0: cnt holds, tc <= 0. tc is therefore a one-cycle pulse, high in the cycle where q shows the wrapped value.
- Out-of-range cnt (> MAX_COUNT) only arises from toggle mode. The counting modes recover as defined above, without a tc pulse.
- Mode change: cnt is retained; the new mode applies from the next enabled edge. Switching 01 to 11 changes q encoding immediately, with no cycle penalty.
- Arithmetic is modulo 2**WIDTH internally. With MAX_COUNT = 2**WIDTH-1, wrap is natural overflow/underflow.
- Latency: q reflects a load/count one cycle after the sampling edge; tc aligns with q.
- No X propagation: all registers are defined after the first reset.

Test Plan:
- WIDTH=4, MAX_COUNT=9, mode=01: reset for 1 cycle, then enable=1 for 12 cycles -> q=1..9,0,1,2; tc=1 only in the cycle q becomes 0; q=0, tc=0 during reset.
- mode=10, enable=1 from q=0 -> q=9,8,7; tc=1 in the cycle q=9 only. Then enable=0 for 3 cycles -> q holds 7, tc=0.
- mode=00, t_in=4'b0101, enable=1 from 0 -> q=0101,0000,0101. t_in=0 -> q holds. enable=0 with t_in=1111 -> q holds.
- Load: mode=01, load_value=14, enable=0 -> q=9 (clamped). mode=00 load 14 -> q=14. Switch to 01, enable -> q=0, tc=0. Simultaneous load=1, enable=1, load_value=3 -> q=3 (load wins).
- Gray: mode=11, MAX_COUNT=15 (WIDTH=4), count 16 steps from 0 -> q=0001,0011,0010,0110,...,1000,0000; exactly one bit changes per step; tc=1 at the wrap to 0000.
- Reset mid-operation: counting at q=6, assert reset together with load=1, load_value=2 -> q=0, tc=0 next cycle. Deassert reset -> count resumes from 0 to 1.
